seven_segment_controller: RTL and testbench

Time-multiplexed driver for a bank of common-anode seven-segment digits. It scans NUM_DIGITS digits one at a time and decodes each 4-bit value to hexadecimal glyphs. It also supports per-digit dash and decimal-point overrides, optional leading-zero blanking, and PWM brightness. Inputs are snapshotted once per frame so the display never shows a mix of two values. It sits between the application logic (range/angle readouts) and the board's cathode/anode pins.

---
 rtl/seven_segment_controller.sv | 190 +++++++++++++++++++
 tb/tb_seven_segment_controller.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_controller.sv
// Time-multiplexed common-anode seven-segment driver: scans digits, decodes hex glyphs,
// applies per-frame input snapshots, leading-zero blanking and PWM brightness.
module seven_segment_controller #(
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned COUNT_PERIOD = 100000,
    parameter int unsigned BRIGHT_W     = 4
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic [4*NUM_DIGITS-1:0] val_in,
    input  logic [NUM_DIGITS-1:0]   dash_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz_in,
    input  logic [BRIGHT_W-1:0]     brightness_in,
    output logic [6:0]              cat_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic                    frame_out
);

    localparam int unsigned CNT_W = (COUNT_PERIOD > 1) ? $clog2(COUNT_PERIOD) : 1;
    localparam int unsigned DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned THR_W = BRIGHT_W + 33;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT_PERIOD - 1);
    localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(NUM_DIGITS - 1);

    function automatic logic [6:0] hex_glyph(input logic [3:0] v);
        logic [6:0] g;
        unique case (v)
            4'h0: g = 7'h3F;
            4'h1: g = 7'h06;
            4'h2: g = 7'h5B;
            4'h3: g = 7'h4F;
            4'h4: g = 7'h66;
            4'h5: g = 7'h6D;
            4'h6: g = 7'h7D;
            4'h7: g = 7'h07;
            4'h8: g = 7'h7F;
            4'h9: g = 7'h6F;
            4'hA: g = 7'h77;
            4'hB: g = 7'h7C;
            4'hC: g = 7'h39;
            4'hD: g = 7'h5E;
            4'hE: g = 7'h79;
            4'hF: g = 7'h71;
        endcase
        return g;
    endfunction

    logic [CNT_W-1:0]        r_cnt;
    logic [DIG_W-1:0]        r_dig;
    logic [4*NUM_DIGITS-1:0] r_sh_val;
    logic [NUM_DIGITS-1:0]   r_sh_dash;
    logic [NUM_DIGITS-1:0]   r_sh_dp;
    logic                    r_sh_blz;
    logic [BRIGHT_W-1:0]     r_sh_bright;
    logic [NUM_DIGITS-1:0]   r_an;
    logic [6:0]              r_cat;
    logic                    r_dpo;
    logic                    r_frame;

    logic                    w_cnt_wrap;
    logic [CNT_W-1:0]        w_cnt_next;
    logic [DIG_W-1:0]        w_dig_next;
    logic                    w_snap;

    logic [4*NUM_DIGITS-1:0] w_val;
    logic [NUM_DIGITS-1:0]   w_dash;
    logic [NUM_DIGITS-1:0]   w_dp;
    logic                    w_blz;
    logic [BRIGHT_W-1:0]     w_bright;

    logic [3:0]              w_cur_val;
    logic                    w_cur_dash;
    logic                    w_cur_dp;
    logic                    w_blank;
    logic                    w_zero_from;

    logic [THR_W-1:0]        w_prod;
    logic [THR_W-1:0]        w_thr;
    logic                    w_on;

    logic [NUM_DIGITS-1:0]   w_an_d;
    logic [6:0]              w_cat_d;
    logic                    w_dp_d;

    always_comb begin
        w_cnt_wrap = (r_cnt == CNT_LAST);
        w_cnt_next = w_cnt_wrap ? '0 : r_cnt + CNT_W'(1);
        w_dig_next = r_dig;
        if (w_cnt_wrap) begin
            w_dig_next = (r_dig == DIG_LAST) ? '0 : r_dig + DIG_W'(1);
        end
        w_snap = (r_cnt == '0) && (r_dig == '0);
    end

    // On the snapshot cycle the shadows are loading this edge, so digit 0 of the
    // new frame is decoded straight from the inputs being latched.
    always_comb begin
        w_val    = w_snap ? val_in        : r_sh_val;
        w_dash   = w_snap ? dash_in       : r_sh_dash;
        w_dp     = w_snap ? dp_in         : r_sh_dp;
        w_blz    = w_snap ? blank_lz_in   : r_sh_blz;
        w_bright = w_snap ? brightness_in : r_sh_bright;
    end

    always_comb begin
        w_cur_val   = 4'h0;
        w_cur_dash  = 1'b0;
        w_cur_dp    = 1'b0;
        w_blank     = 1'b0;
        w_zero_from = 1'b1;
        // Walk from the most significant digit down, tracking "all zero from here up".
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_zero_from = w_zero_from && (w_val[4*i +: 4] == 4'h0) && !w_dash[i] && !w_dp[i];
            if (r_dig == DIG_W'(i)) begin
                w_cur_val  = w_val[4*i +: 4];
                w_cur_dash = w_dash[i];
                w_cur_dp   = w_dp[i];
                w_blank    = w_blz && (i != 0) && w_zero_from;
            end
        end
    end

    always_comb begin
        w_prod = (THR_W'(w_bright) + THR_W'(1)) * THR_W'(COUNT_PERIOD);
        w_thr  = w_prod >> BRIGHT_W;
        w_on   = THR_W'(r_cnt) < w_thr;
    end

    always_comb begin
        w_an_d  = '1;
        w_cat_d = 7'h7F;
        w_dp_d  = 1'b1;
        if (w_on) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (r_dig == DIG_W'(i)) begin
                    w_an_d[i] = 1'b0;
                end
            end
            if (!w_blank) begin
                w_cat_d = ~(w_cur_dash ? 7'h40 : hex_glyph(w_cur_val));
                w_dp_d  = ~w_cur_dp;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_cnt       <= '0;
            r_dig       <= '0;
            r_sh_val    <= '0;
            r_sh_dash   <= '0;
            r_sh_dp     <= '0;
            r_sh_blz    <= 1'b0;
            r_sh_bright <= '0;
        end else begin
            r_cnt <= w_cnt_next;
            r_dig <= w_dig_next;
            if (w_snap) begin
                r_sh_val    <= val_in;
                r_sh_dash   <= dash_in;
                r_sh_dp     <= dp_in;
                r_sh_blz    <= blank_lz_in;
                r_sh_bright <= brightness_in;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_an    <= '1;
            r_cat   <= 7'h7F;
            r_dpo   <= 1'b1;
            r_frame <= 1'b0;
        end else begin
            r_an    <= w_an_d;
            r_cat   <= w_cat_d;
            r_dpo   <= w_dp_d;
            r_frame <= w_snap;
        end
    end

    assign an_out    = r_an;
    assign cat_out   = r_cat;
    assign dp_out    = r_dpo;
    assign frame_out = r_frame;

endmodule

// File: tb/tb_seven_segment_controller.sv
// Scoreboard bench: a frame-position reference model predicts every output cycle;
// a monitor pops predictions and compares them with the DUT on the falling edge.
module tb_seven_segment_controller;

    localparam int ND = 4;
    localparam int CP = 16;
    localparam int BW = 4;
    localparam int FRAME = ND * CP;

    typedef struct packed {
        logic [ND-1:0] an;
        logic [6:0]    cat;
        logic          dp;
        logic          frame;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [4*ND-1:0] val = '0;
    logic [ND-1:0]   dash = '0;
    logic [ND-1:0]   dpi = '0;
    logic            blz = 1'b0;
    logic [BW-1:0]   bright = '0;
    logic [6:0]      cat_out;
    logic            dp_out;
    logic [ND-1:0]   an_out;
    logic            frame_out;

    int checks = 0;
    int errors = 0;
    exp_t q[$];

    logic [6:0] glyph_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    seven_segment_controller #(
        .NUM_DIGITS  (ND),
        .COUNT_PERIOD(CP),
        .BRIGHT_W    (BW)
    ) dut (
        .clk_in       (clk),
        .rst_in       (rst),
        .val_in       (val),
        .dash_in      (dash),
        .dp_in        (dpi),
        .blank_lz_in  (blz),
        .brightness_in(bright),
        .cat_out      (cat_out),
        .dp_out       (dp_out),
        .an_out       (an_out),
        .frame_out    (frame_out)
    );

    always #5 clk = ~clk;

    // Reference model: position within the frame since reset release decides everything.
    initial begin : model
        int t;
        logic [4*ND-1:0] s_val;
        logic [ND-1:0]   s_dash, s_dp;
        logic            s_blz;
        int              s_br;
        t = 0; s_val = '0; s_dash = '0; s_dp = '0; s_blz = 1'b0; s_br = 0;
        forever begin
            exp_t e;
            @(posedge clk);
            if (rst) begin
                t = 0; s_val = '0; s_dash = '0; s_dp = '0; s_blz = 1'b0; s_br = 0;
                e = '{an: '1, cat: 7'h7F, dp: 1'b1, frame: 1'b0};
            end else begin
                int p, d, c, thr;
                bit blank;
                p = t % FRAME;
                d = p / CP;
                c = p % CP;
                if (p == 0) begin
                    s_val = val; s_dash = dash; s_dp = dpi; s_blz = blz; s_br = int'(bright);
                end
                thr = ((s_br + 1) * CP) >> BW;
                blank = 1'b0;
                if (s_blz && d != 0) begin
                    blank = 1'b1;
                    for (int j = d; j < ND; j++)
                        if (s_val[4*j +: 4] != 0 || s_dash[j] || s_dp[j]) blank = 1'b0;
                end
                e = '{an: '1, cat: 7'h7F, dp: 1'b1, frame: (p == 0)};
                if (c < thr) begin
                    e.an[d] = 1'b0;
                    if (!blank) begin
                        e.cat = s_dash[d] ? ~7'h40 : ~glyph_tbl[s_val[4*d +: 4]];
                        e.dp  = ~s_dp[d];
                    end
                end
                t++;
            end
            q.push_back(e);
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                exp_t e;
                exp_t a;
                e = q.pop_front();
                a = '{an: an_out, cat: cat_out, dp: dp_out, frame: frame_out};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL scan t=%0t an/cat/dp/frame got %h/%h/%b/%b want %h/%h/%b/%b",
                             $time, a.an, a.cat, a.dp, a.frame, e.an, e.cat, e.dp, e.frame);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (an_out !== '1 || cat_out !== 7'h7F || dp_out !== 1'b1 || frame_out !== 1'b0) begin
            errors++;
            $display("FAIL %s an/cat/dp/frame got %h/%h/%b/%b want f/7f/1/0",
                     name, an_out, cat_out, dp_out, frame_out);
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        step(3);
        check_reset_outputs("reset_hold");

        val = 16'h1234; bright = 4'hF; rst = 1'b0;
        step(2 * FRAME);

        for (int v = 0; v < 16; v++) begin
            val = {12'($urandom), 4'(v)};
            dpi = 4'($urandom);
            step(FRAME);
        end
        dpi = '0;

        val = 16'h000F; dash = 4'b0001; step(2 * FRAME);
        dash = '0; dpi = 4'b0010; step(2 * FRAME);

        dpi = '0; blz = 1'b1; val = 16'h0050; step(2 * FRAME);
        dpi = 4'b0100; step(2 * FRAME);
        dpi = '0; val = 16'h0000; step(2 * FRAME);

        blz = 1'b0; val = 16'h1234;
        bright = 4'd0;  step(2 * FRAME);
        bright = 4'd7;  step(2 * FRAME);
        bright = 4'd15; step(2 * FRAME);

        val = 16'h1111; step(2 * FRAME);
        step(FRAME + 6);
        val = 16'h2222; step(3 * FRAME);

        repeat (40) begin
            val = 16'($urandom); dash = 4'($urandom); dpi = 4'($urandom);
            blz = 1'($urandom); bright = 4'($urandom);
            step($urandom_range(1, 100));
        end

        bright = 4'hF; dash = '0; dpi = '0; blz = 1'b0; val = 16'h5678;
        rst = 1'b1; step(3);
        rst = 1'b0;
        step(2 * CP + 5);
        rst = 1'b1;
        #1;
        check_reset_outputs("async_reset_mid_frame");
        step(3);
        val = 16'h9ABC;
        rst = 1'b0;
        step(3 * FRAME);

        @(negedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
